// File: rtl/bicubic_upsample_4x_mc.sv
// rtl/bicubic_upsample_4x_mc.sv - two-stage separable bicubic 4x upsampler with raster counters and bypass
module bicubic_upsample_4x_mc #(
   parameter int CHANNEL_WIDTH = 8,
   parameter int NUM_CH        = 3,
   parameter int SRC_WIDTH     = 960,
   parameter int SRC_HEIGHT    = 540
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  cfg_bypass,
   input  logic                                  bf_req_valid,
   output logic                                  bcci_req_ready,
   input  logic [16*NUM_CH*CHANNEL_WIDTH-1:0]    p_win,
   output logic [4*NUM_CH*CHANNEL_WIDTH-1:0]     bcci_rsp_data,
   output logic                                  bcci_rsp_valid,
   input  logic                                  bf_rsp_ready,
   output logic                                  bcci_rsp_eol,
   output logic                                  bcci_rsp_eof
);

   localparam int CW    = CHANNEL_WIDTH;
   localparam int V_W   = CW + 11;
   localparam int A_W   = CW + 21;
   localparam int COL_W = (SRC_WIDTH  > 1) ? $clog2(SRC_WIDTH)  : 1;
   localparam int ROW_W = (SRC_HEIGHT > 1) ? $clog2(SRC_HEIGHT) : 1;

   // Phase weights scaled by 256; set selects the phase, tap selects the source row/column.
   function automatic logic signed [9:0] wgt(input logic [1:0] set, input logic [1:0] tap);
      logic signed [9:0] w;
      case ({set, tap})
         4'd0:    w = -10'sd18;
         4'd1:    w =  10'sd248;
         4'd2:    w =  10'sd29;
         4'd3:    w = -10'sd3;
         4'd4:    w = -10'sd28;
         4'd5:    w =  10'sd192;
         4'd6:    w =  10'sd109;
         4'd7:    w = -10'sd17;
         4'd8:    w = -10'sd17;
         4'd9:    w =  10'sd109;
         4'd10:   w =  10'sd192;
         4'd11:   w = -10'sd28;
         4'd12:   w = -10'sd3;
         4'd13:   w =  10'sd29;
         4'd14:   w =  10'sd248;
         default: w = -10'sd18;
      endcase
      return w;
   endfunction

   // Raster position and frame-level bypass latch
   logic [COL_W-1:0] col_q, col_d;
   logic [1:0]       ph_q, ph_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             bypass_q;

   // Stage 1: vertical sums plus sideband
   logic                    s1_valid_q;
   logic [1:0]              s1_ph_q;
   logic                    s1_eol_q, s1_eof_q, s1_byp_q;
   logic signed [V_W-1:0]   v_q   [NUM_CH][4];
   logic signed [V_W-1:0]   v_d   [NUM_CH][4];
   logic [CW-1:0]           pix11_q [NUM_CH];

   // Stage 2: output beat
   logic                         s2_valid_q;
   logic [4*NUM_CH*CW-1:0]       rsp_data_q, rsp_data_d;
   logic                         rsp_eol_q, rsp_eof_q;

   logic s1_ready, s2_ready, in_hs, s1_adv;
   logic col_last, ph_last, row_last, first_beat, beat_byp;

   logic signed [9:0]     w_s1, w_s2;
   logic signed [V_W-1:0] wext, pext;
   logic signed [A_W-1:0] wext_a, vext_a, a_sum, a_rnd;
   logic [CW-1:0]         pix_val;

   assign s2_ready   = ~s2_valid_q | bf_rsp_ready;
   assign s1_ready   = ~s1_valid_q | s2_ready;
   assign in_hs      = bf_req_valid & s1_ready;
   assign s1_adv     = s1_valid_q & s2_ready;

   assign col_last   = (col_q == COL_W'(SRC_WIDTH - 1));
   assign ph_last    = (ph_q == 2'd3);
   assign row_last   = (row_q == ROW_W'(SRC_HEIGHT - 1));
   assign first_beat = (col_q == '0) && (ph_q == 2'd0) && (row_q == '0);
   // The first beat of a frame already obeys the new mode, later beats use the latch.
   assign beat_byp   = first_beat ? cfg_bypass : bypass_q;

   assign bcci_req_ready = s1_ready;
   assign bcci_rsp_valid = s2_valid_q;
   assign bcci_rsp_data  = rsp_data_q;
   assign bcci_rsp_eol   = rsp_eol_q;
   assign bcci_rsp_eof   = rsp_eof_q;

   // Next raster position: col wraps into ph, ph wraps into row, row wraps into a new frame.
   always_comb begin
      col_d = col_q + 1'b1;
      ph_d  = ph_q;
      row_d = row_q;
      if (col_last) begin
         col_d = '0;
         ph_d  = ph_q + 2'd1;
         if (ph_last) begin
            row_d = row_last ? '0 : row_q + 1'b1;
         end
      end
   end

   // Raster counters and bypass latch advance on every accepted window beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q    <= '0;
         ph_q     <= 2'd0;
         row_q    <= '0;
         bypass_q <= 1'b0;
      end else if (in_hs) begin
         col_q <= col_d;
         ph_q  <= ph_d;
         row_q <= row_d;
         if (first_beat) begin
            bypass_q <= cfg_bypass;
         end
      end
   end

   // Vertical filter: v[c] = sum_r W[ph][r] * p[r][c], full precision.
   always_comb begin
      w_s1 = '0;
      wext = '0;
      pext = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int c = 0; c < 4; c++) begin
            v_d[ch][c] = '0;
         end
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
               w_s1 = wgt(ph_q, 2'(r));
               wext = {{(V_W-10){w_s1[9]}}, w_s1};
               pext = {{(V_W-CW){1'b0}}, p_win[((r*4+c)*NUM_CH+ch)*CW +: CW]};
               v_d[ch][c] = v_d[ch][c] + wext * pext;
            end
         end
      end
   end

   // Stage 1 register: loads on input handshake, holds while stage 2 is blocked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_ph_q    <= 2'd0;
         s1_eol_q   <= 1'b0;
         s1_eof_q   <= 1'b0;
         s1_byp_q   <= 1'b0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            pix11_q[ch] <= '0;
            for (int c = 0; c < 4; c++) begin
               v_q[ch][c] <= '0;
            end
         end
      end else begin
         s1_valid_q <= in_hs | (s1_valid_q & ~s2_ready);
         if (in_hs) begin
            s1_ph_q  <= ph_q;
            s1_eol_q <= col_last;
            s1_eof_q <= col_last & ph_last & row_last;
            s1_byp_q <= beat_byp;
            for (int ch = 0; ch < NUM_CH; ch++) begin
               pix11_q[ch] <= p_win[(5*NUM_CH+ch)*CW +: CW];
               for (int c = 0; c < 4; c++) begin
                  v_q[ch][c] <= v_d[ch][c];
               end
            end
         end
      end
   end

   // Horizontal filter per output k with round-half-up, >>16 and clamp; bypass picks p[1][1].
   always_comb begin
      rsp_data_d = '0;
      w_s2       = '0;
      wext_a     = '0;
      vext_a     = '0;
      a_sum      = '0;
      a_rnd      = '0;
      pix_val    = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int k = 0; k < 4; k++) begin
            a_sum = '0;
            for (int c = 0; c < 4; c++) begin
               w_s2   = wgt(2'(k), 2'(c));
               wext_a = {{(A_W-10){w_s2[9]}}, w_s2};
               vext_a = {{(A_W-V_W){v_q[ch][c][V_W-1]}}, v_q[ch][c]};
               a_sum  = a_sum + wext_a * vext_a;
            end
            a_rnd = a_sum + A_W'(32768);
            if (s1_byp_q) begin
               pix_val = pix11_q[ch];
            end else if (a_rnd[A_W-1]) begin
               pix_val = '0;
            end else if (|a_rnd[A_W-2:16+CW]) begin
               pix_val = '1;
            end else begin
               pix_val = a_rnd[16+CW-1:16];
            end
            rsp_data_d[(k*NUM_CH+ch)*CW +: CW] = pix_val;
         end
      end
   end

   // Stage 2 register: drives the output beat, holds it stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         rsp_data_q <= '0;
         rsp_eol_q  <= 1'b0;
         rsp_eof_q  <= 1'b0;
      end else begin
         s2_valid_q <= s1_adv | (s2_valid_q & ~bf_rsp_ready);
         if (s1_adv) begin
            rsp_data_q <= rsp_data_d;
            rsp_eol_q  <= s1_eol_q;
            rsp_eof_q  <= s1_eof_q;
         end
      end
   end

   // The vertical phase rides along for debug visibility only; the stage-2 weights are per output k.
   logic unused_ph;
   assign unused_ph = ^s1_ph_q;

endmodule

// File: tb/tb_bicubic_upsample_4x_mc.sv
// tb/tb_bicubic_upsample_4x_mc.sv - self-checking bench for bicubic_upsample_4x_mc
module tb_bicubic_upsample_4x_mc;

   localparam int CW    = 8;
   localparam int NCH   = 3;
   localparam int SW    = 4;
   localparam int SH    = 2;
   localparam int FRAME = 4 * SW * SH;
   localparam int PW    = 16 * NCH * CW;
   localparam int DW    = 4 * NCH * CW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_bypass;
   logic          bf_req_valid;
   logic          bcci_req_ready;
   logic [PW-1:0] p_win;
   logic [DW-1:0] bcci_rsp_data;
   logic          bcci_rsp_valid;
   logic          bf_rsp_ready;
   logic          bcci_rsp_eol;
   logic          bcci_rsp_eof;

   bicubic_upsample_4x_mc #(
      .CHANNEL_WIDTH(CW), .NUM_CH(NCH), .SRC_WIDTH(SW), .SRC_HEIGHT(SH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_bypass(cfg_bypass),
      .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready), .p_win(p_win),
      .bcci_rsp_data(bcci_rsp_data), .bcci_rsp_valid(bcci_rsp_valid),
      .bf_rsp_ready(bf_rsp_ready), .bcci_rsp_eol(bcci_rsp_eol), .bcci_rsp_eof(bcci_rsp_eof)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          eol;
      logic          eof;
   } exp_t;

   typedef struct packed {
      logic [3:0][7:0] col;
      logic [3:0][7:0] expv;
   } vec_t;

   int WT [4][4] = '{'{-18, 248, 29, -3}, '{-28, 192, 109, -17},
                     '{-17, 109, 192, -28}, '{-3, 29, 248, -18}};

   exp_t          sb [$];
   vec_t          tbl [4];
   int            errors = 0;
   int            checks = 0;
   int            beat_idx = 0;
   bit            byp_m = 1'b0;
   int            cyc = 0;
   int            rdy_mode = 0;
   bit            ovr = 1'b0;
   logic [DW-1:0] ovr_data = '0;
   bit            arm_lat = 1'b0;
   int            hs_cyc = -1;
   int            v_cyc = -1;
   exp_t          mon_e;
   int            mon_pos;
   logic [PW-1:0] w_tmp;
   logic [DW-1:0] e_tmp;
   logic [DW-1:0] held_data;
   logic          held_eol, held_eof;
   int            acc;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Spec-level reference: separable filter with plain integers, round, shift, clamp.
   function automatic logic [DW-1:0] model(input logic [PW-1:0] w, input int ph, input bit byp);
      logic [DW-1:0] res;
      int v [4];
      int a, o;
      res = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         for (int c = 0; c < 4; c++) begin
            v[c] = 0;
            for (int r = 0; r < 4; r++)
               v[c] += WT[ph][r] * int'(w[((r*4+c)*NCH+ch)*CW +: CW]);
         end
         for (int k = 0; k < 4; k++) begin
            if (byp) begin
               o = int'(w[(5*NCH+ch)*CW +: CW]);
            end else begin
               a = 0;
               for (int c = 0; c < 4; c++) a += WT[k][c] * v[c];
               o = (a + 32768) >>> 16;
               if (o < 0) o = 0;
               if (o > (1 << CW) - 1) o = (1 << CW) - 1;
            end
            res[(k*NCH+ch)*CW +: CW] = o[CW-1:0];
         end
      end
      return res;
   endfunction

   function automatic logic [PW-1:0] rand_win();
      logic [PW-1:0] w;
      for (int i = 0; i < PW / 32; i++) w[i*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [PW-1:0] byp_win();
      logic [PW-1:0] w;
      w = rand_win();
      for (int ch = 0; ch < NCH; ch++) w[(5*NCH+ch)*CW +: CW] = 8'h5A;
      return w;
   endfunction

   task automatic set_vec(input int i, input int c0, input int c1, input int c2, input int c3,
                          input int e0, input int e1, input int e2, input int e3);
      tbl[i].col[0] = 8'(c0); tbl[i].col[1] = 8'(c1); tbl[i].col[2] = 8'(c2); tbl[i].col[3] = 8'(c3);
      tbl[i].expv[0] = 8'(e0); tbl[i].expv[1] = 8'(e1); tbl[i].expv[2] = 8'(e2); tbl[i].expv[3] = 8'(e3);
   endtask

   // Presents one window beat and returns at posedge+1 after it was accepted.
   task automatic send(input logic [PW-1:0] w, input bit ov, input logic [DW-1:0] ovd);
      int  n;
      bit  done;
      p_win        = w;
      ovr          = ov;
      ovr_data     = ovd;
      bf_req_valid = 1'b1;
      done = 1'b0;
      n    = 0;
      while (!done) begin
         @(negedge clk);
         done = bcci_req_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n >= 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
            done = 1'b1;
         end
      end
      bf_req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (n > 0) #1;
      chk("drain_empty", DW'(sb.size()), DW'(0));
   endtask

   task automatic pad_to_frame();
      while (beat_idx % FRAME != 0) send(rand_win(), 1'b0, '0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream ready generator: 0 = always ready, 1 = random, 2 = stalled.
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       bf_rsp_ready = 1'b1;
         1:       bf_rsp_ready = ($urandom_range(0, 3) != 0);
         default: bf_rsp_ready = 1'b0;
      endcase
   end

   // Monitor: scores output handshakes against the queue, queues expectations on input handshakes.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         if (bcci_rsp_valid && arm_lat && v_cyc < 0) v_cyc = cyc;
         if (bcci_rsp_valid && bf_rsp_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got data %h with nothing outstanding, expected no beat", bcci_rsp_data);
            end else begin
               mon_e = sb.pop_front();
               chk("beat_data", bcci_rsp_data, mon_e.data);
               chk("beat_eol", DW'(bcci_rsp_eol), DW'(mon_e.eol));
               chk("beat_eof", DW'(bcci_rsp_eof), DW'(mon_e.eof));
            end
         end
         if (bf_req_valid && bcci_req_ready) begin
            mon_pos = beat_idx % FRAME;
            if (mon_pos == 0) byp_m = cfg_bypass;
            mon_e.data = ovr ? ovr_data : model(p_win, (mon_pos / SW) % 4, byp_m);
            mon_e.eol  = (mon_pos % SW) == SW - 1;
            mon_e.eof  = (mon_pos == FRAME - 1);
            sb.push_back(mon_e);
            beat_idx++;
            if (arm_lat && hs_cyc < 0) hs_cyc = cyc;
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      cfg_bypass   = 1'b0;
      bf_req_valid = 1'b0;
      p_win        = '0;
      bf_rsp_ready = 1'b1;

      set_vec(0, 100, 100, 100, 100, 100, 100, 100, 100);
      set_vec(1,   0, 255, 255,   0, 255, 255, 255, 255);
      set_vec(2,   0,   0, 255, 255,  26,  92, 163, 229);
      set_vec(3, 255,   0,   0, 255,   0,   0,   0,   0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", DW'(bcci_rsp_valid), DW'(0));
      chk("rst_eol", DW'(bcci_rsp_eol), DW'(0));
      chk("rst_eof", DW'(bcci_rsp_eof), DW'(0));
      chk("rst_data", bcci_rsp_data, '0);
      chk("rst_req_ready", DW'(bcci_req_ready), DW'(1));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", DW'(bcci_rsp_valid), DW'(0));
      chk("post_rst_req_ready", DW'(bcci_req_ready), DW'(1));

      // Directed vectors at ph 0: flat field, overshoot clamp, step, undershoot clamp.
      arm_lat = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               for (int ch = 0; ch < NCH; ch++)
                  w_tmp[((r*4+c)*NCH+ch)*CW +: CW] = tbl[i].col[c];
         for (int k = 0; k < 4; k++)
            for (int ch = 0; ch < NCH; ch++)
               e_tmp[(k*NCH+ch)*CW +: CW] = tbl[i].expv[k];
         send(w_tmp, 1'b1, e_tmp);
      end
      ovr = 1'b0;
      drain();
      arm_lat = 1'b0;
      chk("latency", DW'(v_cyc - hs_cyc), DW'(2));

      // Random traversal with random downstream stalls: rest of frame 1 plus frame 2.
      rdy_mode = 1;
      pad_to_frame();
      repeat (FRAME) send(rand_win(), 1'b0, '0);
      drain();
      rdy_mode = 0;
      bf_rsp_ready = 1'b1;
      @(posedge clk);
      #1;

      // Backpressure: stall downstream while the source keeps offering beats.
      rdy_mode     = 2;
      bf_rsp_ready = 1'b0;
      acc          = 0;
      bf_req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         p_win = rand_win();
         @(negedge clk);
         if (bcci_req_ready) acc++;
         if (i == 2) begin
            held_data = bcci_rsp_data;
            held_eol  = bcci_rsp_eol;
            held_eof  = bcci_rsp_eof;
         end
         if (i == 4) begin
            chk("bp_valid_held", DW'(bcci_rsp_valid), DW'(1));
            chk("bp_data_stable", bcci_rsp_data, held_data);
            chk("bp_eol_stable", DW'(bcci_rsp_eol), DW'(held_eol));
            chk("bp_eof_stable", DW'(bcci_rsp_eof), DW'(held_eof));
            chk("bp_req_ready_low", DW'(bcci_req_ready), DW'(0));
         end
         @(posedge clk);
         #1;
      end
      bf_req_valid = 1'b0;
      chk("bp_accepted", DW'(acc), DW'(2));
      rdy_mode     = 0;
      bf_rsp_ready = 1'b1;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         chk("bp_no_gap", DW'(bcci_rsp_valid), DW'(1));
         @(posedge clk);
         #1;
      end
      drain();
      pad_to_frame();
      drain();

      // Bypass frame with a mid-frame toggle, then a normal frame start.
      cfg_bypass = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         if (i == 10) cfg_bypass = 1'b0;
         send(byp_win(), 1'b0, '0);
      end
      repeat (8) send(byp_win(), 1'b0, '0);
      drain();
      pad_to_frame();

      // Reset mid-frame with beats in flight, then restart from ph 0.
      repeat (10) send(rand_win(), 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", DW'(bcci_rsp_valid), DW'(0));
      chk("midrst_data", bcci_rsp_data, '0);
      chk("midrst_req_ready", DW'(bcci_req_ready), DW'(1));
      sb.delete();
      beat_idx = 0;
      byp_m    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (8) send(rand_win(), 1'b0, '0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bicubic_upsample_4x_mc.md
BICUBIC_UPSAMPLE_4X_MC -- requirements
Module: bicubic_upsample_4x_mc

Interface
Parameters:
REQ-001 CHANNEL_WIDTH, 8, bits per colour channel, unsigned.
REQ-002 NUM_CH, 3, colour channels per pixel, 1..4.
REQ-003 SRC_WIDTH, 960, source pixels per line (window beats per output row).
REQ-004 SRC_HEIGHT, 540, source lines per frame.

Ports (name, direction, width, meaning):
REQ-005 clk, in, 1, single clock; rising edge. Reset is asynchronous and active-low.
REQ-006 rst_n, in, 1, asynchronous active-low reset.
REQ-007 cfg_bypass, in, 1, nearest-neighbour mode; sampled only at frame start.
REQ-008 bf_req_valid, in, 1, window beat valid.
REQ-009 bcci_req_ready, out, 1, window beat accepted when high with valid.
REQ-010 p_win, in, 16*NUM_CH*CHANNEL_WIDTH, 4x4 window.
- Pixel idx = r*4+c; r is top-to-bottom, c is left-to-right.
- Channel ch sits at [(idx*NUM_CH+ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH].
REQ-011 bcci_rsp_data, out, 4*NUM_CH*CHANNEL_WIDTH, 4 output pixels, left to right.
- Pixel k, channel ch sits at [(k*NUM_CH+ch)*CHANNEL_WIDTH +: CHANNEL_WIDTH].
REQ-012 bcci_rsp_valid, out, 1, output beat valid.
REQ-013 bf_rsp_ready, in, 1, downstream ready.
REQ-014 bcci_rsp_eol, out, 1, output beat is the last of its output row; qualified by valid.
REQ-015 bcci_rsp_eof, out, 1, output beat is the last of the frame; qualified by valid.

Function
REQ-016 Accept window beats in raster order.
- Each beat yields one 4-pixel output beat for one output row.
- That output row is at vertical phase ph (0..3).
REQ-017 Counters advance on each input handshake:
- col counts 0..SRC_WIDTH-1, then wraps.
- At col wrap, ph increments 0..3.
- At ph wrap, row increments 0..SRC_HEIGHT-1.
- At row wrap, the frame ends.
- One frame = 4*SRC_WIDTH*SRC_HEIGHT beats.
REQ-018 Phase weight set W[ph], scaled by 256:
- W0 = -18, 248, 29, -3
- W1 = -28, 192, 109, -17
- W2 = -17, 109, 192, -28
- W3 = -3, 29, 248, -18
REQ-019 Stage 1 (vertical), per channel and column c: v[c] = sum over r of W[ph][r]*p[r][c].
- Signed result, width at least CHANNEL_WIDTH+11, no truncation.
REQ-020 Stage 2 (horizontal), per channel and output k: a[k] = sum over c of W[k][c]*v[c].
- Signed result, width at least CHANNEL_WIDTH+21.
REQ-021 Output value = (a[k] + 32768) arithmetic-shifted right by 16.
- Results below 0 clamp to 0.
- Results above 2^CHANNEL_WIDTH-1 clamp to 2^CHANNEL_WIDTH-1.
REQ-022 Bypass mode (latched cfg_bypass=1): all 4 output pixels equal p[1][1] for every channel; timing is unchanged.
REQ-023 Pipeline structure:
- Two registered stages, each with its own valid bit.
- sN_ready = ~sN_valid | downstream_ready.
- bcci_req_ready = s1_ready.
- No combinational path from bf_req_valid to bcci_rsp_valid.
REQ-024 Latency is exactly 2 cycles from input handshake to bcci_rsp_valid when bf_rsp_ready is held high.
- Throughput is 1 beat per cycle.
REQ-025 While bcci_rsp_valid=1 and bf_rsp_ready=0:
- bcci_rsp_data, bcci_rsp_eol and bcci_rsp_eof hold stable.
- At most 2 beats are buffered.
- No beat is lost or duplicated.
REQ-026 ph, eol and eof flags are captured at input handshake and travel with the data through both stages.
REQ-027 cfg_bypass is latched when the frame's first beat is accepted (col=0, ph=0, row=0) and held for the frame.
REQ-028 A simultaneous input and output handshake on the same cycle shall not stall the pipeline.

Reset
REQ-029 Asynchronous assertion of rst_n=0 clears:
- col, ph, row
- both stage valid bits
- the bypass latch
REQ-030 During and after reset, outputs are:
- bcci_rsp_valid = 0
- bcci_rsp_eol = 0
- bcci_rsp_eof = 0
- bcci_rsp_data = 0
- bcci_req_ready = 1
REQ-031 Reset mid-frame discards in-flight beats; the next accepted beat is col 0, ph 0, row 0.

Verification
REQ-032 Flat field: all p_win channels = 100, ready high -> every output channel = 100; first valid 2 cycles after first handshake.
REQ-033 Overshoot clamp: ph=0, columns c0,c3 = 0 and c1,c2 = 255 on all rows -> output k=0 = 255 (raw value 275.9); k=1 value checked against the REQ-021 formula.
REQ-034 Traversal (SRC_WIDTH=4, SRC_HEIGHT=2, stream 32 beats) -> 32 outputs:
- eol on beats 4, 8, ..., 32.
- eof only on beat 32.
- Phase sequence 0,0,0,0,1,... matches W per REQ-018.
REQ-035 Backpressure: drive bf_rsp_ready=0 for 5 cycles with bf_req_valid=1 ->
- bcci_req_ready falls after 2 beats are accepted.
- Held output stays stable.
- After release, all beats arrive in order with no gaps or duplicates.
REQ-036 Bypass: cfg_bypass=1 at frame start, p[1][1]=0x5A with random neighbours -> all 4 outputs = 0x5A.
- Toggling cfg_bypass mid-frame has no effect until the next frame.
REQ-037 Reset mid-frame: assert rst_n=0 at beat 10 -> bcci_rsp_valid=0 immediately; a restart yields ph=0 weights and eol after 4 beats.
